// File: rtl/mips_reg_file_sb.sv
// mips_reg_file_sb
// General-purpose register file with two combinational read ports and one
// synchronous write port, dedicated HI/LO registers for multiply/divide
// results, optional write-to-read forwarding and a per-register busy
// scoreboard that decode uses to stall on operands still in flight.
// Register 0 is hard-wired to zero and can never be marked busy.

module mips_reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  rst,
  // writeback side
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] DataIn,
  // decode side: operand reads
  input  logic [ADDR_WIDTH-1:0] Address1,
  input  logic [ADDR_WIDTH-1:0] Address2,
  output logic [DATA_WIDTH-1:0] DataOut1,
  output logic [DATA_WIDTH-1:0] DataOut2,
  output logic                  Busy1,
  output logic                  Busy2,
  // decode side: reservation of a destination for a multi-cycle unit
  input  logic                  ReserveEn,
  input  logic [ADDR_WIDTH-1:0] ReserveAddress,
  // multiply/divide result registers
  input  logic                  HiLoWrite,
  input  logic [DATA_WIDTH-1:0] HiIn,
  input  logic [DATA_WIDTH-1:0] LoIn,
  output logic [DATA_WIDTH-1:0] HiOut,
  output logic [DATA_WIDTH-1:0] LoOut
);

  localparam int                    NREG      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  // Storage and scoreboard state
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_next;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  // Qualified enables: anything aimed at register 0 is dropped up front so
  // neither the storage nor the scoreboard ever sees it.
  logic wr_en;
  logic rsv_en;

  assign wr_en  = RegWrite  && (WriteAddress   != ZERO_ADDR);
  assign rsv_en = ReserveEn && (ReserveAddress != ZERO_ADDR);

  // Read-data selection for one port: zero register, then same-cycle
  // forwarding of the write port, then the stored value.
  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] result;
    if (addr == ZERO_ADDR) begin
      result = '0;
    end else if (BYPASS && we && (waddr == addr)) begin
      result = wdata;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // Busy selection for one port. A completing write hides the busy bit in
  // its own cycle, unless a fresh reservation lands on the same register,
  // because that register will still be pending after the edge.
  function automatic logic busy_mux(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  stored,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic                  re,
    input logic [ADDR_WIDTH-1:0] raddr
  );
    logic result;
    if (addr == ZERO_ADDR) begin
      result = 1'b0;
    end else if (BYPASS && we && (waddr == addr) && !(re && (raddr == addr))) begin
      result = 1'b0;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // GPR array: full clear on reset, otherwise a single write per edge
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WriteAddress] <= DataIn;
    end
  end

  // HI/LO pair is always written together
  always_ff @(posedge CLK) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (HiLoWrite) begin
      hi <= HiIn;
      lo <= LoIn;
    end
  end

  // Scoreboard next state: clear on write-back first, then set on
  // reservation, so a same-cycle reservation of the same register wins.
  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[WriteAddress] = 1'b0;
    end
    if (rsv_en) begin
      busy_next[ReserveAddress] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; reset drops every outstanding reservation
  always_ff @(posedge CLK) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Operand data ports
  assign DataOut1 = read_mux(Address1, regs[Address1], wr_en, WriteAddress, DataIn);
  assign DataOut2 = read_mux(Address2, regs[Address2], wr_en, WriteAddress, DataIn);

  // Operand busy ports
  assign Busy1 = busy_mux(Address1, busy[Address1], wr_en, WriteAddress, rsv_en, ReserveAddress);
  assign Busy2 = busy_mux(Address2, busy[Address2], wr_en, WriteAddress, rsv_en, ReserveAddress);

  // HI/LO read ports, forwarded while a write is in progress
  assign HiOut = (BYPASS && HiLoWrite) ? HiIn : hi;
  assign LoOut = (BYPASS && HiLoWrite) ? LoIn : lo;

endmodule

// File: tb/tb_mips_reg_file_sb.sv
// Self-checking bench for mips_reg_file_sb: one forwarding instance and one
// non-forwarding instance share all inputs; a table of per-cycle vectors
// holds hand-computed expected outputs, followed by a short scoreboard/reset
// sequence.

module tb_mips_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          rst;
  logic          RegWrite;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] DataIn;
  logic [AW-1:0] Address1;
  logic [AW-1:0] Address2;
  logic [DW-1:0] DataOut1;
  logic [DW-1:0] DataOut2;
  logic          Busy1;
  logic          Busy2;
  logic          ReserveEn;
  logic [AW-1:0] ReserveAddress;
  logic          HiLoWrite;
  logic [DW-1:0] HiIn;
  logic [DW-1:0] LoIn;
  logic [DW-1:0] HiOut;
  logic [DW-1:0] LoOut;

  logic [DW-1:0] nb_DataOut1;
  logic [DW-1:0] nb_DataOut2;
  logic          nb_Busy1;
  logic          nb_Busy2;
  logic [DW-1:0] nb_HiOut;
  logic [DW-1:0] nb_LoOut;

  always #5 CLK = ~CLK;

  mips_reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut (
    .CLK(CLK), .rst(rst),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress), .DataIn(DataIn),
    .Address1(Address1), .Address2(Address2),
    .DataOut1(DataOut1), .DataOut2(DataOut2),
    .Busy1(Busy1), .Busy2(Busy2),
    .ReserveEn(ReserveEn), .ReserveAddress(ReserveAddress),
    .HiLoWrite(HiLoWrite), .HiIn(HiIn), .LoIn(LoIn),
    .HiOut(HiOut), .LoOut(LoOut)
  );

  mips_reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .rst(rst),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress), .DataIn(DataIn),
    .Address1(Address1), .Address2(Address2),
    .DataOut1(nb_DataOut1), .DataOut2(nb_DataOut2),
    .Busy1(nb_Busy1), .Busy2(nb_Busy2),
    .ReserveEn(ReserveEn), .ReserveAddress(ReserveAddress),
    .HiLoWrite(HiLoWrite), .HiIn(HiIn), .LoIn(LoIn),
    .HiOut(nb_HiOut), .LoOut(nb_LoOut)
  );

  typedef struct {
    int          rst;
    int          we;
    int          wa;
    logic [31:0] din;
    int          a1;
    int          a2;
    int          rsv;
    int          ra;
    int          hlw;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [31:0] e_do1;
    logic [31:0] e_do2;
    int          e_b1;
    int          e_b2;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [31:0] e_nb_do1;
    int          e_nb_b1;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst            = 1'b0;
    RegWrite       = 1'b0;
    WriteAddress   = '0;
    DataIn         = '0;
    Address1       = '0;
    Address2       = '0;
    ReserveEn      = 1'b0;
    ReserveAddress = '0;
    HiLoWrite      = 1'b0;
    HiIn           = '0;
    LoIn           = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Each vector is one cycle: inputs driven, outputs checked mid-cycle,
    // state commits on the following rising edge.
    //               rst we wa din           a1 a2 rsv ra hlw hi_in lo_in         e_do1         e_do2         b1 b2 e_hi  e_lo          nb_do1        nb_b1
    vecs[0]  = '{0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0, 32'h0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[1]  = '{0, 0, 0, 32'h0,        5, 0, 0, 0, 0, 32'h0, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 32'h0, 32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[3]  = '{0, 0, 0, 32'h0,        0, 5, 0, 0, 0, 32'h0, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[4]  = '{0, 0, 0, 32'h0,        7, 7, 1, 7, 0, 32'h0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[5]  = '{0, 0, 0, 32'h0,        7, 7, 0, 0, 0, 32'h0, 32'h0,        32'h0,        32'h0,        1, 1, 32'h0, 32'h0,        32'h0,        1};
    vecs[6]  = '{0, 1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0, 32'h0, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0,        32'h0,        1};
    vecs[7]  = '{0, 0, 0, 32'h0,        7, 5, 0, 0, 0, 32'h0, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0,        32'hA5A5A5A5, 0};
    vecs[8]  = '{0, 1, 9, 32'hCAFEF00D, 9, 9, 1, 9, 0, 32'h0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[9]  = '{0, 0, 0, 32'h0,        9, 9, 0, 0, 0, 32'h0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 32'h0, 32'h0,        32'hCAFEF00D, 1};
    vecs[10] = '{0, 0, 0, 32'h0,        0, 9, 1, 0, 0, 32'h0, 32'h0,        32'h0,        32'hCAFEF00D, 0, 1, 32'h0, 32'h0,        32'h0,        0};
    vecs[11] = '{0, 0, 0, 32'h0,        0, 9, 0, 0, 0, 32'h0, 32'h0,        32'h0,        32'hCAFEF00D, 0, 1, 32'h0, 32'h0,        32'h0,        0};
    vecs[12] = '{0, 0, 0, 32'h0,        9, 0, 1, 9, 0, 32'h0, 32'h0,        32'hCAFEF00D, 32'h0,        1, 0, 32'h0, 32'h0,        32'hCAFEF00D, 1};
    vecs[13] = '{0, 1, 9, 32'h11111111, 9, 12, 1, 12, 0, 32'h0, 32'h0,      32'h11111111, 32'h0,        0, 0, 32'h0, 32'h0,        32'hCAFEF00D, 1};
    vecs[14] = '{0, 0, 0, 32'h0,        9, 12, 0, 0, 0, 32'h0, 32'h0,       32'h11111111, 32'h0,        0, 1, 32'h0, 32'h0,        32'h11111111, 0};
    vecs[15] = '{0, 0, 0, 32'h0,        5, 9, 0, 0, 1, 32'h1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h11111111, 0, 0, 32'h1, 32'hFFFFFFFF, 32'hDEADBEEF, 0};
    vecs[16] = '{0, 0, 0, 32'h0,        12, 3, 0, 0, 0, 32'h0, 32'h0,       32'h0,        32'h0,        1, 0, 32'h1, 32'hFFFFFFFF, 32'h0,        1};
    vecs[17] = '{1, 1, 3, 32'h77777777, 12, 5, 1, 20, 0, 32'h0, 32'h0,      32'h0,        32'hDEADBEEF, 1, 0, 32'h1, 32'hFFFFFFFF, 32'h0,        1};
    vecs[18] = '{0, 0, 0, 32'h0,        3, 5, 0, 0, 0, 32'h0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[19] = '{0, 0, 0, 32'h0,        12, 9, 0, 0, 0, 32'h0, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0, 32'h0,        32'h0,        0};
    vecs[20] = '{0, 0, 0, 32'h0,        20, 7, 0, 0, 0, 32'h0, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0, 32'h0,        32'h0,        0};

    // Reset for two edges
    idle_inputs();
    rst = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;

    // Every address on both ports reads zero and not busy after reset
    for (int i = 0; i < 32; i++) begin
      Address1 = AW'(i);
      Address2 = AW'(31 - i);
      #1;
      check($sformatf("rst_do1_r%0d", i), DataOut1, 32'h0);
      check($sformatf("rst_do2_r%0d", 31 - i), DataOut2, 32'h0);
      check($sformatf("rst_b1_r%0d", i), 32'(Busy1), 32'h0);
      check($sformatf("rst_b2_r%0d", 31 - i), 32'(Busy2), 32'h0);
      check($sformatf("rst_nb_do1_r%0d", i), nb_DataOut1, 32'h0);
    end
    check("rst_hi", HiOut, 32'h0);
    check("rst_lo", LoOut, 32'h0);

    // Table-driven per-cycle vectors
    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      rst            = (vecs[i].rst != 0);
      RegWrite       = (vecs[i].we != 0);
      WriteAddress   = AW'(vecs[i].wa);
      DataIn         = vecs[i].din;
      Address1       = AW'(vecs[i].a1);
      Address2       = AW'(vecs[i].a2);
      ReserveEn      = (vecs[i].rsv != 0);
      ReserveAddress = AW'(vecs[i].ra);
      HiLoWrite      = (vecs[i].hlw != 0);
      HiIn           = vecs[i].hi_in;
      LoIn           = vecs[i].lo_in;
      #1;
      check($sformatf("v%0d_do1", i), DataOut1, vecs[i].e_do1);
      check($sformatf("v%0d_do2", i), DataOut2, vecs[i].e_do2);
      check($sformatf("v%0d_b1", i), 32'(Busy1), 32'(vecs[i].e_b1));
      check($sformatf("v%0d_b2", i), 32'(Busy2), 32'(vecs[i].e_b2));
      check($sformatf("v%0d_hi", i), HiOut, vecs[i].e_hi);
      check($sformatf("v%0d_lo", i), LoOut, vecs[i].e_lo);
      check($sformatf("v%0d_nb_do1", i), nb_DataOut1, vecs[i].e_nb_do1);
      check($sformatf("v%0d_nb_b1", i), 32'(nb_Busy1), 32'(vecs[i].e_nb_b1));
    end

    // Back-to-back reservations, then reset with a reservation in the same cycle
    @(negedge CLK);
    idle_inputs();
    ReserveEn      = 1'b1;
    ReserveAddress = AW'(15);
    Address1       = AW'(15);
    Address2       = AW'(16);
    #1;
    check("seq_r15_not_yet", 32'(Busy1), 32'h0);
    @(negedge CLK);
    ReserveAddress = AW'(16);
    #1;
    check("seq_r15_set", 32'(Busy1), 32'h1);
    check("seq_r16_not_yet", 32'(Busy2), 32'h0);
    @(negedge CLK);
    ReserveEn = 1'b0;
    #1;
    check("seq_r15_held", 32'(Busy1), 32'h1);
    check("seq_r16_set", 32'(Busy2), 32'h1);
    @(negedge CLK);
    rst            = 1'b1;
    ReserveEn      = 1'b1;
    ReserveAddress = AW'(17);
    @(negedge CLK);
    rst       = 1'b0;
    ReserveEn = 1'b0;
    #1;
    check("seq_r15_cleared", 32'(Busy1), 32'h0);
    check("seq_r16_cleared", 32'(Busy2), 32'h0);
    Address1 = AW'(17);
    #1;
    check("seq_r17_rsv_during_rst", 32'(Busy1), 32'h0);

    // Non-forwarding instance: write visible on both ports only after the edge
    @(negedge CLK);
    RegWrite     = 1'b1;
    WriteAddress = AW'(20);
    DataIn       = 32'h0BADF00D;
    Address1     = AW'(20);
    Address2     = AW'(20);
    #1;
    check("seq_nb_r20_same_cycle", nb_DataOut2, 32'h0);
    check("seq_fw_r20_same_cycle", DataOut2, 32'h0BADF00D);
    @(negedge CLK);
    RegWrite = 1'b0;
    #1;
    check("seq_nb_r20_do1_next", nb_DataOut1, 32'h0BADF00D);
    check("seq_nb_r20_do2_next", nb_DataOut2, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_reg_file_sb.md
# mips_reg_file_sb

Parametrised successor to the core's general-purpose register file. It provides 2^ADDR_WIDTH registers of DATA_WIDTH bits, two combinational read ports and one synchronous write port, with these additions:
- a full synchronous clear of every register;
- optional write-to-read bypass;
- dedicated HI/LO registers for multiply/divide results;
- a per-register busy scoreboard so the decode stage can stall on operands a multi-cycle unit has not yet written back.

It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- DATA_WIDTH, 32, width of every register, HI and LO
- ADDR_WIDTH, 5, register address width; register count = 2^ADDR_WIDTH
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only

Ports:
- CLK  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- RegWrite  in  1  GPR write enable
- WriteAddress  in  ADDR_WIDTH  GPR write target
- DataIn  in  DATA_WIDTH  GPR write data
- Address1, Address2  in  ADDR_WIDTH  read addresses
- DataOut1, DataOut2  out  DATA_WIDTH  read data
- Busy1, Busy2  out  1  scoreboard bit of Address1 / Address2
- ReserveEn  in  1  mark ReserveAddress pending
- ReserveAddress  in  ADDR_WIDTH  register to reserve
- HiLoWrite  in  1  write HI and LO together
- HiIn, LoIn  in  DATA_WIDTH  HI/LO write data
- HiOut, LoOut  out  DATA_WIDTH  HI/LO read data

## Operation
- Register 0:
  - reads always 0;
  - writes to it are discarded;
  - its busy bit is constant 0 and ReserveEn to address 0 is ignored.
- GPR write: on a rising edge with RegWrite=1 and WriteAddress≠0, registers[WriteAddress] takes DataIn.
- Read ports are combinational: DataOutN = registers[AddressN].
  - With BYPASS=1, if RegWrite=1, WriteAddress=AddressN and AddressN≠0, then DataOutN = DataIn in the same cycle.
- HI/LO: on an edge with HiLoWrite=1, HI takes HiIn and LO takes LoIn.
  - With BYPASS=1, HiOut/LoOut show HiIn/LoIn while HiLoWrite=1.
- Scoreboard: one busy bit per register.
  - An edge with ReserveEn=1 sets busy[ReserveAddress].
  - An edge with RegWrite=1 clears busy[WriteAddress].
  - When the reservation and the write target the same address in the same cycle, the bit ends set (a new reservation supersedes the completing write).
  - Reserving an already-busy register keeps it busy; there is no count.
- BusyN = busy[AddressN].
  - With BYPASS=1, BusyN is forced to 0 when a write to AddressN occurs in the current cycle and no same-cycle reservation targets that address.
- Reset: an edge with rst=1 clears all registers, HI, LO and all busy bits.
  - rst overrides RegWrite, HiLoWrite and ReserveEn in the same cycle.
  - Reset asserted in the middle of outstanding reservations clears them.

## Timing
- Write latency: one edge. The value is readable the cycle after the write.
  - With BYPASS=1 it is also readable combinationally in the write cycle.
- Busy bits update on the edge. The set is visible the cycle after ReserveEn.
- No handshakes. Every enable acts on exactly one edge.
- Values after the first reset edge:
  - DataOut1/2 = 0, HiOut/LoOut = 0, Busy1/2 = 0.
  - Before the first reset the contents are undefined.
- Both read ports may address the same register or the write target. Both report identical data.

## Test plan
- Reset, then read all addresses on both ports. Required: every DataOut = 0, HiOut/LoOut = 0, Busy = 0.
- Write 0xDEADBEEF to r5, then read r5 next cycle. Required: 0xDEADBEEF.
  - With BYPASS=1, Address1=5 in the write cycle also shows 0xDEADBEEF.
  - With BYPASS=0 it shows the old value 0.
- Write 0x12345678 to r0. Required: DataOut = 0 on any read of r0, both the same cycle and the next.
- Reserve r7, then read Busy1 next cycle with Address1=7. Required: 1.
  - Then write r7 = 0xA5A5A5A5. Required: Busy1 = 0 the cycle after.
- In the same cycle, write r9 and reserve r9. Required: Busy = 1 the next cycle and data = the written value.
- HiLoWrite with HiIn=0x1, LoIn=0xFFFFFFFF, then assert rst with RegWrite=1 on r3 in the same cycle. Required:
  - Hi/Lo read 0x1/0xFFFFFFFF before the reset;
  - everything reads 0 after it;
  - r3 is not written.
